// File: rtl/k16_front_panel_pkg.sv
// k16_front_panel_pkg: shared FSM state types, command bit positions and button priority helpers.
package k16_front_panel_pkg;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} cmd_state_t;
  typedef enum logic [1:0] {L_LOAD, L_SHIFT, L_LATCH} led_state_t;
  localparam int NBTN = 7;
  localparam int CMD_STOP = 0;
  localparam int CMD_START = 1;
  localparam int CMD_CONTINUE = 2;
  localparam int CMD_INST_STEP = 3;
  localparam int CMD_EXAMINE = 4;
  localparam int CMD_EXAMINE_NEXT = 5;
  localparam int CMD_DEPOSIT = 6;
  function automatic logic [2:0] first_set(input logic [NBTN-1:0] v);
    first_set = 3'd0;
    for (int i = NBTN - 1; i >= 0; i--) if (v[i]) first_set = 3'(i);
  endfunction
  function automatic logic [15:0] cmd_bit(input logic [2:0] idx);
    return idx == 3'd0 ? 16'd1 << CMD_STOP :
           idx == 3'd1 ? 16'd1 << CMD_START :
           idx == 3'd2 ? 16'd1 << CMD_CONTINUE :
           idx == 3'd3 ? 16'd1 << CMD_INST_STEP :
           idx == 3'd4 ? 16'd1 << CMD_EXAMINE :
           idx == 3'd5 ? 16'd1 << CMD_EXAMINE_NEXT :
           idx == 3'd6 ? 16'd1 << CMD_DEPOSIT : 16'd0;
  endfunction
endpackage

// File: rtl/k16_front_panel_debounce.sv
// k16_debounce: 2-FF synchronizer plus counter debounce for one button, with a one-cycle rise event.
module k16_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], d};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign level = r_level;
  assign rise  = r_level & ~r_level_d;
endmodule

// File: rtl/k16_front_panel.sv
// k16_front_panel: debounced console buttons to K16 command pulses, plus serial LED shifter for CPU display words.
module k16_front_panel
  import k16_front_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 5,
  parameter int LED_DIV         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  btn,
  input  logic [15:0] sw,
  input  logic [15:0] cpuOutput0,
  input  logic [15:0] cpuOutput1,
  output logic [15:0] cpuInput0,
  output logic [15:0] cpuInput1,
  output logic        cmd_busy,
  output logic        led_sclk,
  output logic        led_sdata,
  output logic        led_latch
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int DW = $clog2(2 * LED_DIV + 1);

  logic [NBTN-1:0] w_level;
  logic [NBTN-1:0] w_rise;
  logic [NBTN-1:0] w_press;

  for (genvar g = 0; g < NBTN; g++) begin : g_db
    k16_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .d    (btn[g]),
      .level(w_level[g]),
      .rise (w_rise[g])
    );
  end
  assign w_press = w_rise & w_level;

  logic [15:0] r_sw_s1;
  logic [15:0] r_sw_s2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  cmd_state_t  r_cs, w_cs_n;
  logic [PW-1:0] r_pcnt, w_pcnt_n;
  logic [15:0] r_in0, w_in0_n;
  logic [15:0] r_in1, w_in1_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs   <= C_IDLE;
      r_pcnt <= '0;
      r_in0  <= '0;
      r_in1  <= '0;
    end else begin
      r_cs   <= w_cs_n;
      r_pcnt <= w_pcnt_n;
      r_in0  <= w_in0_n;
      r_in1  <= w_in1_n;
    end
  end

  always_comb begin
    w_cs_n   = r_cs;
    w_pcnt_n = r_pcnt;
    w_in0_n  = r_in0;
    w_in1_n  = r_in1;
    case (r_cs)
      C_IDLE:
        if (|w_press) begin
          w_cs_n   = C_PULSE;
          w_pcnt_n = '0;
          w_in1_n  = cmd_bit(first_set(w_press));
        end else w_in0_n = r_sw_s2;
      C_PULSE:
        if (r_pcnt == PW'(PULSE_CYCLES - 1)) begin
          w_cs_n   = C_GAP;
          w_pcnt_n = '0;
          w_in1_n  = '0;
        end else w_pcnt_n = r_pcnt + 1'b1;
      C_GAP:
        if (r_pcnt == PW'(PULSE_CYCLES - 1)) begin
          w_cs_n   = C_IDLE;
          w_pcnt_n = '0;
        end else w_pcnt_n = r_pcnt + 1'b1;
      default: w_cs_n = C_IDLE;
    endcase
  end

  assign cpuInput0 = r_in0;
  assign cpuInput1 = r_in1;
  assign cmd_busy  = r_cs != C_IDLE;

  led_state_t  r_ls, w_ls_n;
  logic [31:0] r_sh, w_sh_n;
  logic [DW-1:0] r_div, w_div_n;
  logic [4:0]  r_bit, w_bit_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ls  <= L_LOAD;
      r_sh  <= '0;
      r_div <= '0;
      r_bit <= '0;
    end else begin
      r_ls  <= w_ls_n;
      r_sh  <= w_sh_n;
      r_div <= w_div_n;
      r_bit <= w_bit_n;
    end
  end

  always_comb begin
    w_ls_n  = r_ls;
    w_sh_n  = r_sh;
    w_div_n = r_div;
    w_bit_n = r_bit;
    case (r_ls)
      L_LOAD: begin
        w_ls_n  = L_SHIFT;
        w_sh_n  = {cpuOutput1, cpuOutput0};
        w_div_n = '0;
        w_bit_n = '0;
      end
      L_SHIFT:
        if (r_div == DW'(2 * LED_DIV - 1)) begin
          w_div_n = '0;
          w_sh_n  = {r_sh[30:0], 1'b0};
          w_bit_n = r_bit + 1'b1;
          w_ls_n  = r_bit == 5'd31 ? L_LATCH : L_SHIFT;
        end else w_div_n = r_div + 1'b1;
      L_LATCH:
        if (r_div == DW'(LED_DIV - 1)) w_ls_n = L_LOAD;
        else w_div_n = r_div + 1'b1;
      default: w_ls_n = L_LOAD;
    endcase
  end

  // Clock low for the first half of each bit period so data is stable at its rising edge.
  assign led_sdata = (r_ls == L_SHIFT) && r_sh[31];
  assign led_sclk  = (r_ls == L_SHIFT) && (r_div >= DW'(LED_DIV));
  assign led_latch = r_ls == L_LATCH;
endmodule

// File: tb/tb_k16_front_panel.sv
// tb_k16_front_panel: scoreboard bench; stimulus queues expected command pulses, a monitor measures and compares them.
module tb_k16_front_panel;
  import k16_front_panel_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  btn;
  logic [15:0] sw;
  logic [15:0] cpuOutput0;
  logic [15:0] cpuOutput1;
  logic [15:0] cpuInput0;
  logic [15:0] cpuInput1;
  logic        cmd_busy;
  logic        led_sclk;
  logic        led_sdata;
  logic        led_latch;

  k16_front_panel dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .sw        (sw),
    .cpuOutput0(cpuOutput0),
    .cpuOutput1(cpuOutput1),
    .cpuInput0 (cpuInput0),
    .cpuInput1 (cpuInput1),
    .cmd_busy  (cmd_busy),
    .led_sclk  (led_sclk),
    .led_sdata (led_sdata),
    .led_latch (led_latch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] in0;
    int          start;
    int          len;
  } exp_t;
  exp_t q[$];

  logic        m_act = 1'b0;
  logic [15:0] m_val;
  logic [15:0] m_in0;
  int          m_start;
  int          m_len;

  initial forever begin
    @(negedge clk);
    if (!m_act && cpuInput1 != 16'd0) begin
      m_act   = 1'b1;
      m_val   = cpuInput1;
      m_in0   = cpuInput0;
      m_start = cyc;
      m_len   = 1;
      chk("busy_with_cmd", {31'd0, cmd_busy}, 32'd1);
    end else if (m_act && cpuInput1 == m_val) m_len++;
    else if (m_act) begin
      m_act = 1'b0;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got %h expected none", m_val);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cmd_value", {16'd0, m_val}, {16'd0, e.cmd});
        chk("cmd_in0", {16'd0, m_in0}, {16'd0, e.in0});
        chk("cmd_start", m_start, e.start);
        chk("cmd_len", m_len, e.len);
      end
    end
  end

  task automatic wait_busy(input logic v, input string name);
    int k = 0;
    while (cmd_busy !== v && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, cmd_busy}, {31'd0, v});
  endtask

  task automatic push(input logic [15:0] cmd, input logic [15:0] in0, input int len);
    exp_t e;
    e.cmd   = cmd;
    e.in0   = in0;
    e.start = cyc + 20;
    e.len   = len;
    q.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, nb, k;
    logic [31:0] bits;
    logic ps;
    reset = 1'b0;
    btn = '0;
    sw = '0;
    cpuOutput1 = 16'hA5A5;
    cpuOutput0 = 16'h0001;
    repeat (3) @(negedge clk);
    chk("rst_in0", {16'd0, cpuInput0}, 32'd0);
    chk("rst_in1", {16'd0, cpuInput1}, 32'd0);
    chk("rst_busy_led", {28'd0, cmd_busy, led_sclk, led_sdata, led_latch}, 32'd0);
    reset = 1'b1;

    // LED frame
    k = 0;
    while (!led_latch && k < 600) begin @(negedge clk); k++; end
    t0 = cyc;
    n = 0;
    while (led_latch && n < 50) begin @(negedge clk); n++; end
    chk("latch_width", n, 4);
    bits = '0; nb = 0; ps = 1'b0; k = 0;
    while (nb < 32 && k < 400) begin
      if (led_sclk && !ps) begin bits = {bits[30:0], led_sdata}; nb++; end
      ps = led_sclk;
      @(negedge clk);
      k++;
    end
    chk("led_bits", bits, 32'hA5A50001);
    k = 0;
    while (!led_latch && k < 600) begin @(negedge clk); k++; end
    t1 = cyc;
    chk("led_period", t1 - t0, 261);

    // INST_STEP with sw=0x0010
    sw = 16'h0010;
    repeat (5) @(negedge clk);
    chk("in0_track", {16'd0, cpuInput0}, 32'h0010);
    btn[3] = 1'b1;
    push(16'd1 << CMD_INST_STEP, 16'h0010, 5);
    repeat (40) @(negedge clk);
    btn[3] = 1'b0;
    repeat (40) @(negedge clk);

    // bouncing EXAMINE yields nothing
    for (int i = 0; i < 10; i++) begin
      btn[4] = ~btn[4];
      repeat (3) @(negedge clk);
    end
    btn[4] = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_busy", {31'd0, cmd_busy}, 32'd0);

    // STOP and DEPOSIT together
    btn = 7'b1000001;
    push(16'd1 << CMD_STOP, 16'h0010, 5);
    repeat (60) @(negedge clk);
    btn = '0;
    repeat (40) @(negedge clk);

    // DEPOSIT freezes the switch word
    sw = 16'h1234;
    repeat (5) @(negedge clk);
    btn[6] = 1'b1;
    push(16'd1 << CMD_DEPOSIT, 16'h1234, 5);
    wait_busy(1'b1, "dep_busy_rise");
    repeat (2) @(negedge clk);
    sw = 16'hFFFF;
    n = 0;
    k = 0;
    while (cmd_busy && k < 50) begin
      if (cpuInput0 != 16'h1234) n++;
      @(negedge clk);
      k++;
    end
    chk("frozen_in0_errs", n, 0);
    chk("idle_in0_held", {16'd0, cpuInput0}, 32'h1234);
    @(negedge clk);
    chk("idle_in0_resume", {16'd0, cpuInput0}, 32'hFFFF);
    btn[6] = 1'b0;
    repeat (40) @(negedge clk);

    // reset during a START pulse
    btn[1] = 1'b1;
    push(16'd1 << CMD_START, 16'hFFFF, 1);
    wait_busy(1'b1, "start_busy_rise");
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_in1", {16'd0, cpuInput1}, 32'd0);
    chk("rst_async_busy", {31'd0, cmd_busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push(16'd1 << CMD_START, 16'hFFFF, 5);
    repeat (60) @(negedge clk);
    btn[1] = 1'b0;
    repeat (40) @(negedge clk);

    chk("queue_empty", q.size(), 0);
    chk("monitor_idle", {31'd0, m_act}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
